// File: rtl/wo_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wo_reg_pkg
// Brief    : Shared types and byte-merge helpers for the write-side control register
// Revision : 1.0 - initial release
// ============================================================================
package wo_reg_pkg;

  // Helpers operate on a fixed maximum width; callers zero-extend and truncate
  localparam int c_MAX_WIDTH = 256;
  localparam int c_STRB_MAX  = c_MAX_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } wo_state_e;

  function automatic logic [c_MAX_WIDTH-1:0] strb_to_mask(input logic [c_STRB_MAX-1:0] strb);
    logic [c_MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < c_STRB_MAX; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  function automatic logic [c_MAX_WIDTH-1:0] byte_merge(
    input logic [c_MAX_WIDTH-1:0] old_val,
    input logic [c_MAX_WIDTH-1:0] data,
    input logic [c_STRB_MAX-1:0]  strb
  );
    logic [c_MAX_WIDTH-1:0] mask;
    mask = strb_to_mask(strb);
    return (old_val & ~mask) | (data & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wo_reg_shadow.sv
`default_nettype none
// ============================================================================
// Module   : wo_reg_shadow
// Brief    : Shadow staging register and IDLE/PENDING FSM producing commit value
// Revision : 1.0 - initial release
// ============================================================================
module wo_reg_shadow
  import wo_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK  = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    accept,
  input  logic                    commit_in,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    commit,
  output logic [DATA_WIDTH-1:0]   commit_value,
  output logic                    pending
);

  wo_state_e             r_state;
  wo_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] w_shadow_nxt;
  logic [DATA_WIDTH-1:0] w_merged;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_shadow <= RESET_VALUE;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    commit       = 1'b0;
    w_merged     = r_shadow;
    if (accept) begin
      w_merged = DATA_WIDTH'(byte_merge(c_MAX_WIDTH'(r_shadow), c_MAX_WIDTH'(wr_data),
                                        c_STRB_MAX'(wr_strb)));
    end
    w_shadow_nxt = w_merged;

    case (r_state)
      ST_IDLE: begin
        if (accept && commit_in) begin
          commit = 1'b1;
        end else if (accept) begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (commit_in) begin
          commit      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Pulse bits must not re-fire on a later commit of an unrelated field
    if (commit) begin
      w_shadow_nxt = (w_merged & ~PULSE_MASK) | (RESET_VALUE & PULSE_MASK);
    end
  end

  assign commit_value = w_merged;
  assign pending      = (r_state == ST_PENDING);

endmodule
`default_nettype wire

// File: rtl/wo_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wo_reg_ctrl
// Brief    : Bus-writable control register with byte strobes, pulse bits, shadow
// Revision : 1.0 - initial release
// ============================================================================
module wo_reg_ctrl
  import wo_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK  = '0,
  parameter bit                    SHADOWED    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    commit_in,
  output logic [DATA_WIDTH-1:0]   value_out,
  output logic                    updated_out,
  output logic                    pending_out
);

  logic                  r_ready;
  logic                  r_updated;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  w_accept;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_val;
  logic [DATA_WIDTH-1:0] w_base;
  logic                  w_pending;

  assign w_accept = wr_valid && r_ready;

  // Value the register falls back to this cycle: pulse bits revert to reset
  assign w_base = (r_value & ~PULSE_MASK) | (RESET_VALUE & PULSE_MASK);

  generate
    if (SHADOWED) begin : g_shadow
      wo_reg_shadow #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .PULSE_MASK  (PULSE_MASK)
      ) u_shadow (
        .clk          (clk),
        .rstn         (rstn),
        .accept       (w_accept),
        .commit_in    (commit_in),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .commit       (w_load),
        .commit_value (w_load_val),
        .pending      (w_pending)
      );
    end else begin : g_direct
      logic w_unused_commit;
      assign w_unused_commit = commit_in;
      assign w_load          = w_accept;
      assign w_load_val      = DATA_WIDTH'(byte_merge(c_MAX_WIDTH'(w_base), c_MAX_WIDTH'(wr_data),
                                                      c_STRB_MAX'(wr_strb)));
      assign w_pending       = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ready   <= 1'b0;
      r_updated <= 1'b0;
      r_value   <= RESET_VALUE;
    end else begin
      r_ready   <= 1'b1;
      r_updated <= w_load;
      r_value   <= w_load ? w_load_val : w_base;
    end
  end

  assign wr_ready    = r_ready;
  assign value_out   = r_value;
  assign updated_out = r_updated;
  assign pending_out = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_wo_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wo_reg_ctrl
// Brief    : Scoreboard bench for direct, pulse-bit and shadowed register variants
// Revision : 1.0 - initial release
// ============================================================================
module tb_wo_reg_ctrl;

  typedef struct {
    logic [15:0] value;
    logic        upd;
    logic        pend;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  s;
    logic        c;
    logic [15:0] ev;
    logic        eu;
    logic        ep;
  } stim_t;

  logic        clk;
  logic        rstn;
  logic [15:0] wr_data;
  logic [1:0]  wr_strb;
  logic        commit;
  logic        valid_dir, valid_pul, valid_shd;
  logic        ready_dir, ready_pul, ready_shd;
  logic [15:0] value_dir, value_pul, value_shd;
  logic        upd_dir, upd_pul, upd_shd;
  logic        pend_dir, pend_pul, pend_shd;

  int   n_asserts;
  int   n_fail;
  exp_t sb[$];

  wo_reg_ctrl #(.DATA_WIDTH(16)) dut_dir (
    .clk(clk), .rstn(rstn), .wr_valid(valid_dir), .wr_ready(ready_dir),
    .wr_data(wr_data), .wr_strb(wr_strb), .commit_in(commit),
    .value_out(value_dir), .updated_out(upd_dir), .pending_out(pend_dir)
  );

  wo_reg_ctrl #(.DATA_WIDTH(16), .PULSE_MASK(16'h0001)) dut_pul (
    .clk(clk), .rstn(rstn), .wr_valid(valid_pul), .wr_ready(ready_pul),
    .wr_data(wr_data), .wr_strb(wr_strb), .commit_in(commit),
    .value_out(value_pul), .updated_out(upd_pul), .pending_out(pend_pul)
  );

  wo_reg_ctrl #(.DATA_WIDTH(16), .PULSE_MASK(16'h0001), .SHADOWED(1'b1)) dut_shd (
    .clk(clk), .rstn(rstn), .wr_valid(valid_shd), .wr_ready(ready_shd),
    .wr_data(wr_data), .wr_strb(wr_strb), .commit_in(commit),
    .value_out(value_shd), .updated_out(upd_shd), .pending_out(pend_shd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus from a negedge and returns at the next negedge
  task automatic apply(input int sel, input stim_t st);
    valid_dir = (sel == 0) && st.v;
    valid_pul = (sel == 1) && st.v;
    valid_shd = (sel == 2) && st.v;
    wr_data   = st.d;
    wr_strb   = st.s;
    commit    = st.c;
    sb.push_back('{value: st.ev, upd: st.eu, pend: st.ep});
    @(negedge clk);
    valid_dir = 1'b0;
    valid_pul = 1'b0;
    valid_shd = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_asserts++;
    if ({value_dir, value_pul, value_shd} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_value: got %h %h %h, want 0000 0000 0000", value_dir, value_pul, value_shd);
    end
    n_asserts++;
    if ({ready_dir, ready_pul, ready_shd, upd_dir, upd_pul, upd_shd, pend_dir, pend_pul, pend_shd} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy=%b%b%b upd=%b%b%b pend=%b%b%b, want all 0",
               ready_dir, ready_pul, ready_shd, upd_dir, upd_pul, upd_shd, pend_dir, pend_pul, pend_shd);
    end
    rstn = 1'b1;
    #1;
    n_asserts++;
    if ({ready_dir, ready_pul, ready_shd} !== 3'b000) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b%b%b, want 000", ready_dir, ready_pul, ready_shd);
    end
    @(negedge clk);
    n_asserts++;
    if ({ready_dir, ready_pul, ready_shd} !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b%b%b, want 111", ready_dir, ready_pul, ready_shd);
    end
  endtask

  task automatic test_direct();
    stim_t tbl[9] = '{
      '{1'b1, 16'hA5C3, 2'b11, 1'b0, 16'hA5C3, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'hA5C3, 1'b0, 1'b0},
      '{1'b1, 16'hFF00, 2'b01, 1'b0, 16'hA500, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'hA500, 1'b0, 1'b0},
      '{1'b1, 16'h1234, 2'b00, 1'b0, 16'hA500, 1'b1, 1'b0},
      '{1'b1, 16'h0001, 2'b11, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{1'b1, 16'h0002, 2'b11, 1'b0, 16'h0002, 1'b1, 1'b0},
      '{1'b1, 16'h7703, 2'b10, 1'b0, 16'h7702, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h7702, 1'b0, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      apply(0, tbl[i]);
      e = sb.pop_front();
      n_asserts++;
      if (value_dir !== e.value || upd_dir !== e.upd || pend_dir !== e.pend || ready_dir !== 1'b1) begin
        n_fail++;
        $display("FAIL direct[%0d]: got val=%h upd=%b pend=%b rdy=%b, want val=%h upd=%b pend=%b rdy=1",
                 i, value_dir, upd_dir, pend_dir, ready_dir, e.value, e.upd, e.pend);
      end
    end
  endtask

  task automatic test_pulse();
    stim_t tbl[7] = '{
      '{1'b1, 16'h0011, 2'b11, 1'b0, 16'h0011, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0010, 1'b0, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0010, 1'b0, 1'b0},
      '{1'b1, 16'h0001, 2'b11, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{1'b1, 16'h0001, 2'b01, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b1, 16'h0100, 2'b10, 1'b0, 16'h0100, 1'b1, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      apply(1, tbl[i]);
      e = sb.pop_front();
      n_asserts++;
      if (value_pul !== e.value || upd_pul !== e.upd || pend_pul !== e.pend) begin
        n_fail++;
        $display("FAIL pulse[%0d]: got val=%h upd=%b pend=%b, want val=%h upd=%b pend=%b",
                 i, value_pul, upd_pul, pend_pul, e.value, e.upd, e.pend);
      end
    end
  endtask

  task automatic test_shadow();
    stim_t tbl[13] = '{
      '{1'b1, 16'h1200, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{1'b1, 16'h0034, 2'b01, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h1234, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h1234, 1'b0, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h1234, 1'b0, 1'b0},
      '{1'b1, 16'h1200, 2'b10, 1'b0, 16'h1234, 1'b0, 1'b1},
      '{1'b1, 16'h00EE, 2'b01, 1'b1, 16'h12EE, 1'b1, 1'b0},
      '{1'b1, 16'h0001, 2'b01, 1'b0, 16'h12EE, 1'b0, 1'b1},
      '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h1201, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h1200, 1'b0, 1'b0},
      '{1'b1, 16'h0300, 2'b10, 1'b0, 16'h1200, 1'b0, 1'b1},
      '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h0300, 1'b1, 1'b0},
      '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0300, 1'b0, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      apply(2, tbl[i]);
      e = sb.pop_front();
      n_asserts++;
      if (value_shd !== e.value || upd_shd !== e.upd || pend_shd !== e.pend) begin
        n_fail++;
        $display("FAIL shadow[%0d]: got val=%h upd=%b pend=%b, want val=%h upd=%b pend=%b",
                 i, value_shd, upd_shd, pend_shd, e.value, e.upd, e.pend);
      end
    end
  endtask

  task automatic test_reset_pending();
    stim_t stage  = '{1'b1, 16'hBEEF, 2'b11, 1'b0, 16'h0300, 1'b0, 1'b1};
    stim_t late_c = '{1'b0, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0};
    stim_t idle   = '{1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0};
    exp_t e;
    apply(2, stage);
    e = sb.pop_front();
    n_asserts++;
    if (value_shd !== e.value || pend_shd !== e.pend) begin
      n_fail++;
      $display("FAIL rst_pend_stage: got val=%h pend=%b, want val=%h pend=%b",
               value_shd, pend_shd, e.value, e.pend);
    end
    rstn = 1'b0;
    #1;
    n_asserts++;
    if (value_shd !== 16'h0000 || pend_shd !== 1'b0 || ready_shd !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pend_async: got val=%h pend=%b rdy=%b, want val=0000 pend=0 rdy=0",
               value_shd, pend_shd, ready_shd);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    apply(2, late_c);
    e = sb.pop_front();
    n_asserts++;
    if (value_shd !== e.value || upd_shd !== e.upd || pend_shd !== e.pend) begin
      n_fail++;
      $display("FAIL rst_pend_commit: got val=%h upd=%b pend=%b, want val=%h upd=%b pend=%b",
               value_shd, upd_shd, pend_shd, e.value, e.upd, e.pend);
    end
    apply(2, idle);
    e = sb.pop_front();
    n_asserts++;
    if (value_shd !== e.value || upd_shd !== e.upd || pend_shd !== e.pend) begin
      n_fail++;
      $display("FAIL rst_pend_idle: got val=%h upd=%b pend=%b, want val=%h upd=%b pend=%b",
               value_shd, upd_shd, pend_shd, e.value, e.upd, e.pend);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    wr_data   = '0;
    wr_strb   = '0;
    commit    = 1'b0;
    valid_dir = 1'b0;
    valid_pul = 1'b0;
    valid_shd = 1'b0;
    test_reset();
    test_direct();
    test_pulse();
    test_shadow();
    test_reset_pending();
    n_asserts++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
